// File: rtl/mem_initiator.sv
// mem_initiator: sequences one or two MOV/MOC four-phase transfers toward the byte RAM.
// Define MEM_INIT_TIMEOUT_EN to abort a transfer when MOC stays low for TIMEOUT cycles.
module mem_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [2:0]  REQ_SIZE,
    input  logic [31:0] REQ_ADDR,
    input  logic [63:0] REQ_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [63:0] RDATA,
    output logic        MOV,
    output logic        MEM_RW,
    output logic [2:0]  MEM_MS,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MOC,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_XFER    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_NEXT    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [2:0] SZ_WORD  = 3'b000;
    localparam logic [2:0] SZ_BYTE  = 3'b001;
    localparam logic [2:0] SZ_HALF  = 3'b010;
    localparam logic [2:0] SZ_DWORD = 3'b011;

    logic [2:0]  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mov_q, mov_d;
    logic        mem_rw_q, mem_rw_d;
    logic [2:0]  mem_ms_q, mem_ms_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rw_q, rw_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] whi_q, whi_d;
    logic        half_q, half_d;
    logic        req_legal;
`ifdef MEM_INIT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
    logic [7:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        case (REQ_SIZE)
            SZ_WORD, SZ_DWORD: req_legal = (REQ_ADDR[1:0] == 2'b00);
            SZ_HALF:           req_legal = ~REQ_ADDR[0];
            SZ_BYTE:           req_legal = 1'b1;
            default:           req_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mov_d       = mov_q;
        mem_rw_d    = mem_rw_q;
        mem_ms_d    = mem_ms_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        rw_d        = rw_q;
        size_d      = size_q;
        addr_d      = addr_q;
        whi_d       = whi_q;
        half_d      = half_q;
`ifdef MEM_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    rw_d   = REQ_RW;
                    size_d = REQ_SIZE;
                    addr_d = REQ_ADDR;
                    whi_d  = REQ_WDATA[63:32];
                    half_d = 1'b0;
                    if (!req_legal) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_XFER;
                        mov_d       = 1'b1;
                        mem_rw_d    = REQ_RW;
                        mem_ms_d    = (REQ_SIZE == SZ_DWORD) ? SZ_WORD : REQ_SIZE;
                        mem_addr_d  = REQ_ADDR;
                        mem_wdata_d = REQ_WDATA[31:0];
`ifdef MEM_INIT_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                    end
                end
            end
            S_XFER: begin
                if (MOC) begin
                    mov_d   = 1'b0;
                    state_d = S_RELEASE;
                    if (rw_q) begin
                        // Single-word reads clear the upper half; doubleword fills low then high.
                        if (!half_q) begin
                            rdata_d[31:0] = MEM_RDATA;
                            if (size_q != SZ_DWORD) rdata_d[63:32] = 32'd0;
                        end else begin
                            rdata_d[63:32] = MEM_RDATA;
                        end
                    end
                end
`ifdef MEM_INIT_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_LIMIT) begin
                        mov_d   = 1'b0;
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_RELEASE: begin
                if (!MOC) begin
                    if (size_q == SZ_DWORD && !half_q) begin
                        state_d     = S_NEXT;
                        half_d      = 1'b1;
                        mem_addr_d  = addr_q + 32'd4;
                        mem_wdata_d = whi_q;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                state_d = S_XFER;
                mov_d   = 1'b1;
`ifdef MEM_INIT_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                mov_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mov_q       <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_ms_q    <= 3'b000;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 64'd0;
            rw_q        <= 1'b0;
            size_q      <= 3'b000;
            addr_q      <= 32'd0;
            whi_q       <= 32'd0;
            half_q      <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mov_q       <= mov_d;
            mem_rw_q    <= mem_rw_d;
            mem_ms_q    <= mem_ms_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            whi_q       <= whi_d;
            half_q      <= half_d;
`ifdef MEM_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign RDATA     = rdata_q;
    assign MOV       = mov_q;
    assign MEM_RW    = mem_rw_q;
    assign MEM_MS    = mem_ms_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule
